// File: rtl/regfile_8x4_if.sv
// Bus bundle for the 8x4 scratch register file: one shared address, write
// strobe with data, and the combinational read-back of the addressed entry.
interface regfile_8x4_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
);
  logic                  load;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] q;

  modport master (
    output load,
    output addr,
    output din,
    input  q
  );

  modport slave (
    input  load,
    input  addr,
    input  din,
    output q
  );
endinterface

// File: rtl/regfile_8x4.sv
// Eight-entry by four-bit register file: synchronous write, combinational read
// on the same address, asynchronous whole-array clear that outranks writes.
module regfile_8x4 #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic          clk,
  input  logic          clr,
  regfile_8x4_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] entry [DEPTH];
  logic [DEPTH-1:0]      wr_sel;

  // One-hot write select so each entry owns an independent enable.
  always_comb begin
    wr_sel = '0;
    if (bus.load) begin
      wr_sel[bus.addr] = 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        entry[i] <= '0;
      end else if (wr_sel[i]) begin
        entry[i] <= bus.din;
      end
    end
  end

  // Read path has no bypass: q only ever shows stored contents.
  assign bus.q = entry[bus.addr];

endmodule

// File: tb/tb_regfile_8x4.sv
// Directed and seeded-random checks for regfile_8x4 against a local array model.
module tb_regfile_8x4;

  logic       clk;
  logic       clr;
  logic [3:0] model [8];
  int         n_checks;
  int         n_fail;

  regfile_8x4_if #(.DATA_WIDTH(4), .ADDR_WIDTH(3)) bus ();

  regfile_8x4 #(.DATA_WIDTH(4), .ADDR_WIDTH(3)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(negedge clk);
    bus.load = 1'b0;
    bus.addr = 3'd0;
    bus.din  = 4'h0;
    clr = 1'b1;
    #1;
    n_checks++;
    if (bus.q !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_q: got %h, expected 0", bus.q);
    end
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 4'h0;
  endtask

  task automatic test_power_up();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.addr = 3'(i);
      #1;
      n_checks++;
      if (bus.q !== 4'h0) begin
        n_fail++;
        $display("FAIL power_up addr=%0d: got %h, expected 0", i, bus.q);
      end
    end
  endtask

  // Writes one entry; checks old data before the edge and new data after.
  task automatic do_write(input logic [2:0] a, input logic [3:0] d, input string tag);
    @(negedge clk);
    bus.load = 1'b1;
    bus.addr = a;
    bus.din  = d;
    #1;
    n_checks++;
    if (bus.q !== model[a]) begin
      n_fail++;
      $display("FAIL %s pre_edge addr=%0d: got %h, expected %h", tag, a, bus.q, model[a]);
    end
    @(posedge clk);
    model[a] = d;
    @(negedge clk);
    n_checks++;
    if (bus.q !== d) begin
      n_fail++;
      $display("FAIL %s post_edge addr=%0d: got %h, expected %h", tag, a, bus.q, d);
    end
    bus.load = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) do_write(3'(i), 4'(1 + i), "fill");
    for (int i = 0; i < 8; i++) do_write(3'(i), 4'(8 + i), "overwrite");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.addr = 3'(i);
      #1;
      n_checks++;
      if (bus.q !== 4'(8 + i)) begin
        n_fail++;
        $display("FAIL overwrite_sweep addr=%0d: got %h, expected %h", i, bus.q, 4'(8 + i));
      end
    end
  endtask

  task automatic test_clear();
    @(negedge clk);
    bus.addr = 3'd6;
    #2;
    clr = 1'b1;
    #1;
    n_checks++;
    if (bus.q !== 4'h0) begin
      n_fail++;
      $display("FAIL clear_async: got %h, expected 0", bus.q);
    end
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 4'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.addr = 3'(i);
      #1;
      n_checks++;
      if (bus.q !== 4'h0) begin
        n_fail++;
        $display("FAIL clear_sweep addr=%0d: got %h, expected 0", i, bus.q);
      end
    end
  endtask

  task automatic test_clear_priority();
    @(negedge clk);
    clr      = 1'b1;
    bus.load = 1'b1;
    bus.addr = 3'd3;
    bus.din  = 4'hA;
    @(posedge clk);
    @(negedge clk);
    bus.load = 1'b0;
    clr      = 1'b0;
    #1;
    n_checks++;
    if (bus.q !== 4'h0) begin
      n_fail++;
      $display("FAIL clear_priority: got %h, expected 0", bus.q);
    end
    do_write(3'd3, 4'h5, "post_clear_write");
  endtask

  task automatic test_random();
    logic [2:0] a;
    logic [3:0] d;
    for (int k = 0; k < 32; k++) begin
      a = 3'($urandom_range(7, 0));
      d = 4'($urandom_range(15, 0));
      do_write(a, d, "random");
      @(negedge clk);
      a = 3'($urandom_range(7, 0));
      bus.addr = a;
      #1;
      n_checks++;
      if (bus.q !== model[a]) begin
        n_fail++;
        $display("FAIL random_read iter=%0d addr=%0d: got %h, expected %h", k, a, bus.q, model[a]);
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    bus.load = 1'b0;
    bus.addr = 3'd5;
    bus.din  = ~model[5];
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.q !== model[5]) begin
      n_fail++;
      $display("FAIL hold addr=5: got %h, expected %h", bus.q, model[5]);
    end
    do_write(3'd2, ~model[2], "isolation");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.addr = 3'(i);
      #1;
      n_checks++;
      if (bus.q !== model[i]) begin
        n_fail++;
        $display("FAIL isolation_sweep addr=%0d: got %h, expected %h", i, bus.q, model[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.load = 1'b1;
    bus.addr = 3'd1; bus.din = 4'hC;
    @(negedge clk);
    bus.addr = 3'd4; bus.din = 4'h3;
    @(negedge clk);
    bus.addr = 3'd1; bus.din = 4'h9;
    @(negedge clk);
    bus.load = 1'b0;
    model[1] = 4'h9;
    model[4] = 4'h3;
    bus.addr = 3'd1;
    #1;
    n_checks++;
    if (bus.q !== 4'h9) begin
      n_fail++;
      $display("FAIL back_to_back addr=1: got %h, expected 9", bus.q);
    end
    bus.addr = 3'd4;
    #1;
    n_checks++;
    if (bus.q !== 4'h3) begin
      n_fail++;
      $display("FAIL back_to_back addr=4: got %h, expected 3", bus.q);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr      = 1'b0;
    bus.load = 1'b0;
    bus.addr = 3'd0;
    bus.din  = 4'h0;
    test_reset();
    test_power_up();
    test_fill();
    test_clear();
    test_clear_priority();
    test_random();
    test_hold();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
